// File: rtl/simd_op_controller.sv
// rtl/simd_op_controller.sv - NOP/LOAD/MUL/STORE sequencer for the SIMD register file and multiply ALU
// Optional wait timeout enabled by defining SIMD_CTRL_TIMEOUT_EN.
module simd_op_controller #(
    parameter int ADDR_W    = 8,
    parameter int TIMEOUT_W = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [1:0]        instr_reg,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              alu_start,
    input  logic              alu_done,
    output logic              rf_write_en,
    output logic              rf_load_en,
    output logic [1:0]        rf_dst_reg,
    output logic [1:0]        rf_src_sel,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_MEM_RD, S_LOAD_WR, S_ALU_RUN, S_ALU_WR, S_MEM_WR, S_ERR
    } state_t;

`ifdef SIMD_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // Last wait cycle is reached when the counter holds 2**TIMEOUT_W-2 (cleared to 0 on entry).
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state, state_nxt;
    logic [1:0]           reg_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 first_q;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0]     retired_q;
    logic                 accept;
    logic                 timeout;
    logic                 retire;

    assign instr_ready = (state == S_IDLE) & ~rst;
    assign accept      = instr_valid & instr_ready;
    assign timeout     = TMO_EN & (tmo_cnt == TMO_LAST);
    assign retire      = (accept & (instr_op == 2'b00)) |
                         ((state != S_IDLE) & (state_nxt == S_IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            reg_q     <= '0;
            addr_q    <= '0;
            first_q   <= 1'b0;
            tmo_cnt   <= '0;
            retired_q <= '0;
        end else begin
            state   <= state_nxt;
            first_q <= (state_nxt == S_ALU_RUN) & (state != S_ALU_RUN);
            if (accept) begin
                reg_q  <= instr_reg;
                addr_q <= instr_addr;
            end
            if (state_nxt != state)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            if (retire)
                retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (instr_op)
                        2'b01:   state_nxt = S_MEM_RD;
                        2'b10:   state_nxt = S_ALU_RUN;
                        2'b11:   state_nxt = S_MEM_WR;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_MEM_RD: begin
                if (mem_ack)      state_nxt = S_LOAD_WR;
                else if (timeout) state_nxt = S_ERR;
            end
            S_LOAD_WR: state_nxt = S_IDLE;
            S_ALU_RUN: begin
                if (alu_done)     state_nxt = S_ALU_WR;
                else if (timeout) state_nxt = S_ERR;
            end
            S_ALU_WR: state_nxt = S_IDLE;
            S_MEM_WR: begin
                if (mem_ack)      state_nxt = S_IDLE;
                else if (timeout) state_nxt = S_ERR;
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        alu_start   = 1'b0;
        rf_write_en = 1'b0;
        rf_load_en  = 1'b0;
        rf_dst_reg  = 2'b00;
        rf_src_sel  = 2'b00;
        case (state)
            S_MEM_RD:  mem_req = 1'b1;
            S_LOAD_WR: begin
                rf_write_en = 1'b1;
                rf_load_en  = 1'b1;
                rf_dst_reg  = reg_q;
            end
            S_ALU_RUN: alu_start = first_q;
            S_ALU_WR:  rf_write_en = 1'b1;
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                rf_src_sel = reg_q;
            end
            default: ;
        endcase
    end

    assign mem_addr = addr_q;
    assign busy     = (state != S_IDLE);
    assign err      = TMO_EN & (state == S_ERR);
    assign retired  = retired_q;

endmodule

// File: tb/tb_simd_op_controller.sv
// tb/tb_simd_op_controller.sv - scoreboard bench for simd_op_controller
module tb_simd_op_controller;

    localparam int ADDR_W    = 8;
    localparam int TIMEOUT_W = 4;
    localparam int CNT_W     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [1:0]        instr_op = 2'b00;
    logic [1:0]        instr_reg = 2'b00;
    logic [ADDR_W-1:0] instr_addr = '0;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic              alu_start;
    logic              alu_done = 1'b0;
    logic              rf_write_en, rf_load_en;
    logic [1:0]        rf_dst_reg, rf_src_sel;
    logic              busy, err;
    logic [CNT_W-1:0]  retired;

    simd_op_controller #(.ADDR_W(ADDR_W), .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_reg(instr_reg), .instr_addr(instr_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .alu_start(alu_start), .alu_done(alu_done),
        .rf_write_en(rf_write_en), .rf_load_en(rf_load_en),
        .rf_dst_reg(rf_dst_reg), .rf_src_sel(rf_src_sel),
        .busy(busy), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    // wr_q: {load_en, dst}; mem_q: {we, src, addr}
    logic [2:0]        wr_q[$];
    logic [ADDR_W+2:0] mem_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rf_write_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", rf_write_en, 0);
                end else begin
                    logic [2:0] e;
                    e = wr_q.pop_front();
                    check("wr_load_en", rf_load_en, e[2]);
                    if (e[2]) check("wr_dst_reg", rf_dst_reg, e[1:0]);
                end
            end
            if (mem_req && mem_ack) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem", mem_req, 0);
                end else begin
                    logic [ADDR_W+2:0] m;
                    m = mem_q.pop_front();
                    check("mem_we", mem_we, m[ADDR_W+2]);
                    check("mem_addr", mem_addr, m[ADDR_W-1:0]);
                    if (m[ADDR_W+2]) check("mem_src_sel", rf_src_sel, m[ADDR_W+1:ADDR_W]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        wr_q.delete();
        mem_q.delete();
        exp_ret = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] r, input logic [ADDR_W-1:0] a);
        check("ready_before_issue", instr_ready, 1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_reg   = r;
        instr_addr  = a;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic run_load(input logic [1:0] r, input logic [ADDR_W-1:0] a, input int k);
        wr_q.push_back({1'b1, r});
        mem_q.push_back({1'b0, 2'b00, a});
        issue(2'b01, r, a);
        for (int c = 1; c <= k; c++) begin
            check("load_mem_req", mem_req, 1);
            check("load_mem_addr", mem_addr, a);
            check("load_no_early_write", rf_write_en, 0);
            if (c == k) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("load_write_strobe", {rf_write_en, rf_load_en, rf_dst_reg}, {2'b11, r});
        check("load_req_dropped", mem_req, 0);
        tick();
        exp_ret++;
        check("load_idle", instr_ready, 1);
        check("load_retired", retired, exp_ret);
    endtask

    task automatic run_mul(input int k);
        wr_q.push_back(3'b000);
        issue(2'b10, 2'b00, '0);
        for (int c = 1; c <= k; c++) begin
            check("mul_alu_start", alu_start, (c == 1));
            check("mul_busy", busy, 1);
            check("mul_err_clear", err, 0);
            if (c == k) alu_done = 1'b1;
            tick();
        end
        alu_done = 1'b0;
        check("mul_write_strobe", {rf_write_en, rf_load_en, alu_start}, 3'b100);
        tick();
        exp_ret++;
        check("mul_idle", instr_ready, 1);
        check("mul_retired", retired, exp_ret);
    endtask

    task automatic run_store(input logic [1:0] r, input logic [ADDR_W-1:0] a, input int k);
        mem_q.push_back({1'b1, r, a});
        issue(2'b11, r, a);
        for (int c = 1; c <= k; c++) begin
            check("store_req_we", {mem_req, mem_we}, 2'b11);
            check("store_src_sel", rf_src_sel, r);
            check("store_no_write", rf_write_en, 0);
            if (c == k) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        exp_ret++;
        check("store_idle", instr_ready, 1);
        check("store_req_dropped", mem_req, 0);
        check("store_retired", retired, exp_ret);
    endtask

    initial begin
        tick();
        check("reset_ready", instr_ready, 0);
        check("reset_outputs",
              {mem_req, mem_we, alu_start, rf_write_en, rf_load_en, busy, err},
              7'b0);
        check("reset_regs", {mem_addr, rf_dst_reg, rf_src_sel, retired}, 0);
        rst = 1'b0;
        #1;
        check("release_ready", instr_ready, 1);
        tick();

        run_load(2'd1, 8'h10, 3);
        run_mul(1);
        run_mul(3);
        run_store(2'd3, 8'hA5, 5);
        run_load(2'd2, 8'hFF, 1);

        // Stray handshakes while idle must not move the controller
        mem_ack  = 1'b1;
        alu_done = 1'b1;
        tick();
        mem_ack  = 1'b0;
        alu_done = 1'b0;
        check("ignored_busy", busy, 0);
        check("ignored_retired", retired, exp_ret);

        // Back-to-back NOP, NOP, LOAD with valid held high
        do_reset();
        instr_valid = 1'b1;
        instr_op    = 2'b00;
        tick();
        check("nop1_retired", retired, 1);
        check("nop1_ready", instr_ready, 1);
        tick();
        check("nop2_retired", retired, 2);
        wr_q.push_back({1'b1, 2'd2});
        mem_q.push_back({1'b0, 2'b00, 8'h20});
        instr_op   = 2'b01;
        instr_reg  = 2'd2;
        instr_addr = 8'h20;
        tick();
        instr_op = 2'b11;
        check("b2b_memrd_ready", instr_ready, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("b2b_loadwr_ready", instr_ready, 0);
        check("b2b_write", rf_write_en, 1);
        tick();
        instr_valid = 1'b0;
        check("b2b_done_ready", instr_ready, 1);
        check("b2b_retired", retired, 3);
        tick();
        check("b2b_no_accept", busy, 0);

        // Reset in the middle of a LOAD
        exp_ret = 3'd3;
        wr_q.push_back({1'b1, 2'd1});
        mem_q.push_back({1'b0, 2'b00, 8'h33});
        issue(2'b01, 2'd1, 8'h33);
        tick();
        check("abort_in_memrd", mem_req, 1);
        rst = 1'b1;
        #1;
        wr_q.delete();
        mem_q.delete();
        exp_ret = '0;
        check("abort_outputs_zero",
              {mem_req, mem_we, alu_start, rf_write_en, rf_load_en, busy, err, instr_ready},
              8'b0);
        check("abort_regs_zero", {mem_addr, rf_dst_reg, rf_src_sel, retired}, 0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_release_ready", instr_ready, 1);
        check("abort_release_retired", retired, 0);
        tick();
        tick();
        check("abort_stays_idle", busy, 0);

        // Retired counter wraps from all-ones to zero
        instr_valid = 1'b1;
        instr_op    = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_ret++;
            check("wrap_retired", retired, exp_ret);
        end
        instr_valid = 1'b0;
        tick();

`ifdef SIMD_CTRL_TIMEOUT_EN
        do_reset();
        issue(2'b10, 2'b00, '0);
        for (int c = 1; c <= 15; c++) begin
            check("tmo_wait_err", err, 0);
            tick();
        end
        check("tmo_err", err, 1);
        check("tmo_ready", instr_ready, 0);
        check("tmo_busy", busy, 1);
        check("tmo_strobes", {mem_req, alu_start, rf_write_en}, 3'b000);
        alu_done    = 1'b1;
        instr_valid = 1'b1;
        tick();
        tick();
        alu_done    = 1'b0;
        instr_valid = 1'b0;
        check("tmo_sticky", err, 1);
        check("tmo_no_retire", retired, 0);
        do_reset();
        check("tmo_reset_clears", {err, busy}, 2'b00);
`else
        run_mul(20);
        check("no_tmo_err", err, 0);
`endif

        check("wr_q_drained", wr_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
